// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU result path.
//   - TPU_LANE_W / TPU_LANES : element width and elements per C word
//   - TPU_WORD_W             : width of one C buffer word
//   - rd_state_e             : c_readout FSM states
//   - c_lane()               : C word lane extraction (lane 0 = MSBs)
//   - tile_count()           : number of 4-column tiles for N columns
//   - last_tile_lanes()      : populated lanes in the final tile
// -----------------------------------------------------------------------------
package tpu_pkg;

  localparam int TPU_LANE_W = 32;
  localparam int TPU_LANES  = 4;
  localparam int TPU_WORD_W = TPU_LANE_W * TPU_LANES;
  localparam int TPU_LIW    = $clog2(TPU_LANES);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

  // Lane 0 occupies the top bits of the word, lane 3 the bottom bits.
  function automatic logic [TPU_LANE_W-1:0] c_lane(
    input logic [TPU_WORD_W-1:0] word,
    input logic [TPU_LIW-1:0]    lane
  );
    logic [TPU_WORD_W-1:0] sh;
    sh = word << (TPU_LANE_W * int'(lane));
    return sh[TPU_WORD_W-1 -: TPU_LANE_W];
  endfunction

  // ceil(N/4); N=255 gives 64, so 7 bits are needed.
  function automatic logic [6:0] tile_count(input logic [7:0] n);
    logic [8:0] sum;
    sum = {1'b0, n} + 9'd3;
    return sum[8:2];
  endfunction

  // N - 4*(T-1), i.e. 1..4 for any N > 0.
  function automatic logic [TPU_LIW:0] last_tile_lanes(input logic [7:0] n);
    logic [TPU_LIW:0] k;
    if (n[1:0] == 2'd0) k = 3'd4;
    else                k = {1'b0, n[1:0]};
    return k;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
// Two-entry synchronous FIFO holding C words returned from the result buffer.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored. Storage is not reset, only the pointers.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i/din_i : write strobe and word
//   pop_i        : remove head word
//   dout_o       : head word (meaningful when !empty_o)
//   full_o, empty_o, count_o : occupancy status
// -----------------------------------------------------------------------------
module word_fifo #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/c_readout.sv
// -----------------------------------------------------------------------------
// c_readout
// Drains the M x N int32 result matrix C from the TPU result buffer and
// streams it row-major over a valid/ready handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, M, N           : launch pulse and matrix size (sampled in IDLE)
//   busy, done            : run status; done pulses once per run
//   c_rd_en, c_index      : result buffer read strobe / word address
//   c_rd_data             : word returned one cycle after c_rd_en
//   out_valid, out_ready  : element stream handshake
//   out_data, out_last    : element and end-of-matrix marker
// Buffer layout: column tile t, row r sits at word t*M + r. Reads walk the
// words in emission order (row outer, tile inner) so the emit side simply
// drains a FIFO. At most two words are buffered or in flight.
// -----------------------------------------------------------------------------
module c_readout
  import tpu_pkg::*;
#(
  parameter int LANE_W = TPU_LANE_W,
  parameter int LANES  = TPU_LANES,
  parameter int IDX_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              M,
  input  logic [7:0]              N,
  output logic                    busy,
  output logic                    done,
  output logic                    c_rd_en,
  output logic [IDX_W-1:0]        c_index,
  input  logic [LANE_W*LANES-1:0] c_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic                    out_last
);

  localparam int LIW = $clog2(LANES);

  rd_state_e state_q, state_d;

  // Run parameters latched at start.
  logic [7:0]       m_q, m_d;
  logic [6:0]       t_q, t_d;
  logic [LIW:0]     last_k_q, last_k_d;

  // Read-side walk.
  logic [7:0]       rd_row_q, rd_row_d;
  logic [6:0]       rd_tile_q, rd_tile_d;
  logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
  logic             rd_all_q, rd_all_d;
  logic             inflight_q, inflight_d;

  // Emit-side walk.
  logic [7:0]       em_row_q, em_row_d;
  logic [6:0]       em_tile_q, em_tile_d;
  logic [LIW-1:0]   em_lane_q, em_lane_d;

  logic                    accept;
  logic                    fifo_pop;
  logic [LANE_W*LANES-1:0] fifo_head;
  logic                    fifo_full, fifo_empty;
  logic [1:0]              fifo_count;
  logic                    slot_free;
  logic                    em_last_tile, em_last_row, em_last_lane;
  logic [LIW:0]            em_k;
  logic                    hs, final_hs;

  word_fifo #(
    .WIDTH (LANE_W*LANES)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   (c_rd_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign accept = (state_q == RD_IDLE) && start;

  // Emit side: lane position within the head word.
  assign em_last_tile = (em_tile_q == t_q - 7'd1);
  assign em_last_row  = (em_row_q == m_q - 8'd1);
  assign em_k         = em_last_tile ? last_k_q : (LIW+1)'(LANES);
  assign em_last_lane = (em_lane_q == LIW'(em_k - 1'b1));

  assign out_valid = (state_q == RD_RUN) && !fifo_empty;
  assign out_data  = out_valid ? c_lane(fifo_head, em_lane_q) : '0;
  assign out_last  = out_valid && em_last_lane && em_last_tile && em_last_row;

  assign hs       = out_valid && out_ready;
  assign fifo_pop = hs && em_last_lane;
  assign final_hs = hs && em_last_lane && em_last_tile && em_last_row;

  // Buffered + in-flight words never exceed two. Both occupied-by-two cases
  // are listed; a pop this cycle frees a slot, which keeps single-lane words
  // streaming without bubbles.
  assign slot_free = !(fifo_full || ((fifo_count == 2'd1) && inflight_q)) || fifo_pop;

  assign c_rd_en = (state_q == RD_RUN) && !rd_all_q && slot_free;
  assign c_index = rd_addr_q;

  assign busy = (state_q != RD_IDLE);
  assign done = (state_q == RD_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: begin
        if (start) begin
          if ((M == 8'd0) || (N == 8'd0)) state_d = RD_DONE;
          else                            state_d = RD_RUN;
        end
      end
      RD_RUN: begin
        if (final_hs) state_d = RD_DONE;
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    m_d        = m_q;
    t_d        = t_q;
    last_k_d   = last_k_q;
    rd_row_d   = rd_row_q;
    rd_tile_d  = rd_tile_q;
    rd_addr_d  = rd_addr_q;
    rd_all_d   = rd_all_q;
    inflight_d = c_rd_en;
    em_row_d   = em_row_q;
    em_tile_d  = em_tile_q;
    em_lane_d  = em_lane_q;

    if (accept) begin
      m_d      = M;
      t_d      = tile_count(N);
      last_k_d = last_tile_lanes(N);
    end

    // Address runs +M per tile and restarts at r+1 on each new row.
    if (c_rd_en) begin
      if (rd_tile_q == t_q - 7'd1) begin
        rd_tile_d = 7'd0;
        rd_addr_d = IDX_W'(rd_row_q) + IDX_W'(1);
        if (rd_row_q == m_q - 8'd1) rd_all_d = 1'b1;
        else                        rd_row_d = rd_row_q + 8'd1;
      end else begin
        rd_tile_d = rd_tile_q + 7'd1;
        rd_addr_d = rd_addr_q + IDX_W'(m_q);
      end
    end

    if (hs) begin
      if (em_last_lane) begin
        em_lane_d = '0;
        if (em_last_tile) begin
          em_tile_d = 7'd0;
          em_row_d  = em_row_q + 8'd1;
        end else begin
          em_tile_d = em_tile_q + 7'd1;
        end
      end else begin
        em_lane_d = em_lane_q + 1'b1;
      end
    end

    // Walks are cleared on the way out so IDLE starts from index 0.
    if (state_q == RD_DONE) begin
      rd_row_d  = 8'd0;
      rd_tile_d = 7'd0;
      rd_addr_d = '0;
      rd_all_d  = 1'b0;
      em_row_d  = 8'd0;
      em_tile_d = 7'd0;
      em_lane_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      m_q        <= 8'd0;
      t_q        <= 7'd0;
      last_k_q   <= '0;
      rd_row_q   <= 8'd0;
      rd_tile_q  <= 7'd0;
      rd_addr_q  <= '0;
      rd_all_q   <= 1'b0;
      inflight_q <= 1'b0;
      em_row_q   <= 8'd0;
      em_tile_q  <= 7'd0;
      em_lane_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      t_q        <= t_d;
      last_k_q   <= last_k_d;
      rd_row_q   <= rd_row_d;
      rd_tile_q  <= rd_tile_d;
      rd_addr_q  <= rd_addr_d;
      rd_all_q   <= rd_all_d;
      inflight_q <= inflight_d;
      em_row_q   <= em_row_d;
      em_tile_q  <= em_tile_d;
      em_lane_q  <= em_lane_d;
    end
  end

endmodule

// File: tb/tb_c_readout.sv
// Self-checking bench for c_readout: table of run records plus random runs,
// a C buffer model answering reads, and a scoreboard built from the matrix
// definition (element (r,c) = salt + r*N + c + 1).
module tb_c_readout;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   m_in, n_in;
  logic         busy, done, c_rd_en;
  logic [15:0]  c_index;
  logic [127:0] c_rd_data;
  logic         out_valid, out_ready, out_last;
  logic [31:0]  out_data;

  c_readout dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .M         (m_in),
    .N         (n_in),
    .busy      (busy),
    .done      (done),
    .c_rd_en   (c_rd_en),
    .c_index   (c_index),
    .c_rd_data (c_rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        wlast;
  } elem_t;

  typedef struct {
    int m; int n; int duty; int salt; int poke;
    int n_elems; int n_reads; int done_k;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int duty     = 100;

  logic [127:0] cmem [0:1023];
  elem_t        exp_q[$];
  int           idx_q[$];
  elem_t        e_cur;

  bit          mon_on = 0;
  int          hs_cnt, rd_cnt, wpop_cnt, valid_cnt, max_outst;
  bit          prev_stall;
  logic [31:0] prev_data;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(99) < duty);
    end
  end

  // C buffer: data valid one cycle after the read strobe, junk otherwise.
  always @(posedge clk)
    c_rd_data <= c_rd_en ? cmem[c_index[9:0]] : {4{32'hBAD0_BAD0}};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_cnt - wpop_cnt > max_outst) max_outst = rd_cnt - wpop_cnt;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (c_rd_en) begin
        rd_cnt++;
        chk("read_expected", idx_q.size() != 0, 1);
        if (idx_q.size() != 0) chk("rd_index", c_index, idx_q.pop_front());
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        chk("elem_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          chk("out_data", out_data, e_cur.data);
          chk("out_last", out_last, e_cur.last);
          if (e_cur.wlast) wpop_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Build the buffer image and the expected streams from the matrix rules.
  task automatic prep(input int m, input int n, input int salt);
    int t_cnt;
    logic [127:0] w;
    logic [31:0]  v;
    t_cnt = (n + 3) / 4;
    exp_q.delete();
    idx_q.delete();
    for (int r = 0; r < m; r++)
      for (int t = 0; t < t_cnt; t++) begin
        w = '0;
        for (int l = 0; l < 4; l++) begin
          if (4*t + l < n) v = salt + r*n + (4*t + l) + 1;
          else             v = 32'hDEAD_0000 + 4*t + l;
          w[127 - 32*l -: 32] = v;
        end
        cmem[t*m + r] = w;
        idx_q.push_back(t*m + r);
      end
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        e_cur.data  = salt + r*n + c + 1;
        e_cur.last  = (r == m-1) && (c == n-1);
        e_cur.wlast = (c % 4 == 3) || (c == n-1);
        exp_q.push_back(e_cur);
      end
    hs_cnt = 0; rd_cnt = 0; wpop_cnt = 0; valid_cnt = 0; max_outst = 0;
    prev_stall = 0;
  endtask

  task automatic launch(input int m, input int n);
    @(negedge clk);
    start = 1'b1;
    m_in  = 8'(m);
    n_in  = 8'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    m_in  = 8'($urandom);
    n_in  = 8'($urandom);
  endtask

  task automatic run_case(input vec_t v);
    int k;
    bit got;
    prep(v.m, v.n, v.salt);
    duty   = v.duty;
    mon_on = 1;
    launch(v.m, v.n);
    got = 0;
    k   = -1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_start", busy, 1);
      if (v.poke != 0 && i == 3) begin
        start = 1'b1; m_in = 8'd1; n_in = 8'd1;
      end else if (v.poke != 0 && i == 4) begin
        start = 1'b0;
      end
      if (done) begin got = 1; k = i; end
    end
    chk("done_seen", got, 1);
    if (v.done_k >= 0) chk("done_latency", k, v.done_k);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
    mon_on = 0;
    chk("elem_count", hs_cnt, v.n_elems);
    chk("read_count", rd_cnt, v.n_reads);
    chk("elems_left", exp_q.size(), 0);
    chk("reads_left", idx_q.size(), 0);
    chk("valid_seen", valid_cnt > 0, v.n_elems > 0);
    chk("max_outstanding_le2", max_outst <= 2, 1);
    duty = 100;
  endtask

  vec_t vecs [10];
  vec_t rv;
  bit   hit;

  initial begin
    //          m  n  duty salt poke elems reads done_k
    vecs[0] = '{4, 4, 100, 0,   0,   16,   4,    18};
    vecs[1] = '{3, 6, 100, 100, 0,   18,   6,    20};
    vecs[2] = '{4, 4, 30,  0,   0,   16,   4,    -1};
    vecs[3] = '{0, 5, 100, 7,   0,   0,    0,    0};
    vecs[4] = '{5, 0, 100, 7,   0,   0,    0,    0};
    vecs[5] = '{1, 1, 100, 55,  0,   1,    1,    3};
    vecs[6] = '{2, 7, 100, 300, 0,   14,   4,    16};
    vecs[7] = '{3, 9, 100, 900, 0,   27,   9,    29};
    vecs[8] = '{5, 5, 50,  77,  0,   25,   10,   -1};
    vecs[9] = '{4, 4, 100, 500, 1,   16,   4,    18};

    rst_n = 1'b0; start = 1'b0; m_in = 8'd0; n_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c_rd_en", c_rd_en, 0);
    chk("rst_c_index", c_index, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_case(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.m       = $urandom_range(10, 1);
      rv.n       = $urandom_range(13, 1);
      rv.duty    = (i % 2 == 0) ? 100 : $urandom_range(80, 20);
      rv.salt    = $urandom;
      rv.poke    = 0;
      rv.n_elems = rv.m * rv.n;
      rv.n_reads = rv.m * ((rv.n + 3) / 4);
      rv.done_k  = (rv.duty == 100) ? 2 + rv.m * rv.n : -1;
      run_case(rv);
    end

    // Reset after 5 of 16 elements, then a fresh small run.
    prep(4, 4, 1000);
    duty   = 100;
    mon_on = 1;
    launch(4, 4);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (hs_cnt == 5) hit = 1;
    end
    chk("reached_5_elems", hit, 1);
    mon_on = 0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_c_rd_en", c_rd_en, 0);
    chk("midrst_c_index", c_index, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{2, 2, 100, 2000, 0, 4, 2, 6};
    run_case(rv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
